// File: rtl/lc3_control_fsm_pkg.sv
// ----------------------------------------------------------------------------
// lc3_ctrl_pkg
// Shared definitions for the LC-3 control sequencer:
//   - state_t    : sequencer state encoding
//   - OP_*       : IR[15:12] opcodes the sequencer executes
//   - PCMUX_*, ALU_*, A2_* : datapath select encodings
//   - is_mem_state() : true for states that hold an SRAM access open
// ----------------------------------------------------------------------------
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        HALTED,
        FETCH1,
        FETCH_RD,
        FETCH3,
        DECODE,
        ADD,
        AND,
        NOT,
        BR_CHK,
        BR1,
        JMP,
        JSR1,
        JSR2,
        LDR1,
        LDR_RD,
        LDR3,
        STR1,
        STR2,
        STR_WR,
        PAUSE1,
        PAUSE2
    } state_t;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    // PC source select
    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    // ALU function select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

    // Address adder operand-2 select
    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

    // States that keep an SRAM cycle open and are timed by the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH_RD) || (s == LDR_RD) || (s == STR_WR);
    endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// ----------------------------------------------------------------------------
// lc3_control_fsm_if
// Control bundle between the LC-3 sequencer and its datapath / SRAM.
//   Inputs to the sequencer : Run, Continue, IR[15:0], BEN
//   Register loads          : LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG,
//                             LD_PC, LD_LED
//   Bus drivers             : GatePC, GateMDR, GateALU, GateMARMUX
//   Mux selects             : PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
//                             ADDR2MUX, ALUK, MIO_EN
//   SRAM strobes (low-true) : CE, UB, LB, OE, WE
// master = sequencer side, slave = datapath side.
// ----------------------------------------------------------------------------
interface lc3_control_fsm_if;

    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;

    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic [1:0]  ALUK;
    logic        CE, UB, LB, OE, WE;
    logic        MIO_EN;

    modport master (
        input  Run, Continue, IR, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output CE, UB, LB, OE, WE, MIO_EN
    );

    modport slave (
        output Run, Continue, IR, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  CE, UB, LB, OE, WE, MIO_EN
    );

endinterface

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// 3-bit down counter that times an SRAM access.
//   Clk      : rising-edge clock
//   Reset    : synchronous, active-low; clears the count
//   load     : load load_val on the next edge (asserted when entering an
//              access state)
//   load_val : cycles-minus-one for the access
//   done     : count has reached zero -> current cycle is the last one
// The counter holds at zero instead of wrapping.
// ----------------------------------------------------------------------------
module mem_wait_timer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       done
);

    logic [2:0] count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign done = (count == 3'd0);

endmodule

// File: rtl/lc3_control_fsm.sv
// ----------------------------------------------------------------------------
// lc3_control_fsm
// Moore-style LC-3 instruction sequencer. Steps fetch / decode / execute for
// ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE; other opcodes act as NOPs.
// Every SRAM read or write is held open for MEM_WAIT cycles.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-low; returns to HALTED from any state
//   bus   : lc3_control_fsm_if.master (Run/Continue/IR/BEN in, all loads,
//           gates, selects and SRAM strobes out)
// Parameter MEM_WAIT : SRAM access cycles per read/write, 1..7.
// ----------------------------------------------------------------------------
module lc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    lc3_control_fsm_if.master     bus
);

    import lc3_ctrl_pkg::*;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_t state;
    state_t next_state;
    logic   wait_load;
    logic   wait_done;

    mem_wait_timer u_mem_wait_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .done     (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= HALTED;
        end else begin
            state <= next_state;
        end
    end

    // The timer is armed on the edge that enters an access state, so the
    // first access cycle already sees MEM_WAIT-1 and the last one sees 0.
    assign wait_load = is_mem_state(next_state) && (next_state != state);

    always_comb begin
        next_state = state;
        case (state)
            HALTED:   if (bus.Run) next_state = FETCH1;
            FETCH1:   next_state = FETCH_RD;
            FETCH_RD: if (wait_done) next_state = FETCH3;
            FETCH3:   next_state = DECODE;
            DECODE: begin
                case (bus.IR[15:12])
                    OP_ADD:   next_state = ADD;
                    OP_AND:   next_state = AND;
                    OP_NOT:   next_state = NOT;
                    OP_BR:    next_state = BR_CHK;
                    OP_JMP:   next_state = JMP;
                    OP_JSR:   next_state = JSR1;
                    OP_LDR:   next_state = LDR1;
                    OP_STR:   next_state = STR1;
                    OP_PAUSE: next_state = PAUSE1;
                    default:  next_state = FETCH1;
                endcase
            end
            ADD, AND, NOT: next_state = FETCH1;
            BR_CHK:   next_state = bus.BEN ? BR1 : FETCH1;
            BR1:      next_state = FETCH1;
            JMP:      next_state = FETCH1;
            JSR1:     next_state = JSR2;
            JSR2:     next_state = FETCH1;
            LDR1:     next_state = LDR_RD;
            LDR_RD:   if (wait_done) next_state = LDR3;
            LDR3:     next_state = FETCH1;
            STR1:     next_state = STR2;
            STR2:     next_state = STR_WR;
            STR_WR:   if (wait_done) next_state = FETCH1;
            // Two-step handshake: one PAUSE completes per press/release.
            PAUSE1:   if (bus.Continue) next_state = PAUSE2;
            PAUSE2:   if (!bus.Continue) next_state = FETCH1;
            default:  next_state = HALTED;
        endcase
    end

    always_comb begin
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = PCMUX_INC;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = A2_ZERO;
        bus.ALUK       = ALU_ADD;
        bus.CE         = 1'b1;
        bus.UB         = 1'b0;
        bus.LB         = 1'b0;
        bus.OE         = 1'b1;
        bus.WE         = 1'b1;
        bus.MIO_EN     = 1'b0;

        case (state)
            FETCH1: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.PCMUX  = PCMUX_INC;
                bus.LD_PC  = 1'b1;
            end
            FETCH_RD, LDR_RD: begin
                bus.CE     = 1'b0;
                bus.OE     = 1'b0;
                bus.MIO_EN = 1'b1;
                // Capture read data only once the access time has elapsed.
                bus.LD_MDR = wait_done;
            end
            FETCH3: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
            end
            DECODE: begin
                bus.LD_BEN = 1'b1;
            end
            ADD, AND, NOT: begin
                bus.SR1MUX  = 1'b0;
                bus.SR2MUX  = bus.IR[5];
                bus.GateALU = 1'b1;
                bus.DRMUX   = 1'b0;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                case (state)
                    AND:     bus.ALUK = ALU_AND;
                    NOT:     bus.ALUK = ALU_NOT;
                    default: bus.ALUK = ALU_ADD;
                endcase
            end
            BR1: begin
                bus.ADDR1MUX = 1'b1;
                bus.ADDR2MUX = A2_OFF9;
                bus.PCMUX    = PCMUX_ADDR;
                bus.LD_PC    = 1'b1;
            end
            JMP: begin
                bus.SR1MUX   = 1'b0;
                bus.ADDR1MUX = 1'b0;
                bus.ADDR2MUX = A2_ZERO;
                bus.PCMUX    = PCMUX_ADDR;
                bus.LD_PC    = 1'b1;
            end
            JSR1: begin
                // Link: R7 <- PC (already incremented during fetch).
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
            end
            JSR2: begin
                bus.PCMUX = PCMUX_ADDR;
                bus.LD_PC = 1'b1;
                if (bus.IR[11]) begin
                    bus.ADDR1MUX = 1'b1;
                    bus.ADDR2MUX = A2_OFF11;
                end else begin
                    // JSRR: base register through the adder with zero offset.
                    bus.ADDR1MUX = 1'b0;
                    bus.SR1MUX   = 1'b0;
                    bus.ADDR2MUX = A2_ZERO;
                end
            end
            LDR1, STR1: begin
                bus.SR1MUX     = 1'b0;
                bus.ADDR1MUX   = 1'b0;
                bus.ADDR2MUX   = A2_OFF6;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            LDR3: begin
                bus.GateMDR = 1'b1;
                bus.DRMUX   = 1'b0;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            STR2: begin
                // Source register sits in IR[11:9] for stores.
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = ALU_PASSA;
                bus.GateALU = 1'b1;
                bus.MIO_EN  = 1'b0;
                bus.LD_MDR  = 1'b1;
            end
            STR_WR: begin
                bus.CE = 1'b0;
                bus.WE = 1'b0;
                bus.OE = 1'b1;
            end
            PAUSE1: begin
                bus.LD_LED = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
